// File: rtl/proto_pkg.sv
// Shared types and constants for the RFID link frame parser.
package proto_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'hAA;

    localparam int CHK_SUM = 0;
    localparam int CHK_XOR = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TYPE,
        ST_LEN,
        ST_PAY,
        ST_CHK
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_BAD_LEN = 3'd1,
        ERR_BAD_CHK = 3'd2,
        ERR_OVERRUN = 3'd3,
        ERR_TIMEOUT = 3'd4
    } err_t;

endpackage

// File: rtl/proto_chk_acc.sv
// Running 8-bit frame checksum: additive (wrapping) or XOR, seeded by the TYPE byte.
module proto_chk_acc
    import proto_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       seed,
    input  logic       acc,
    input  logic [7:0] din,
    input  logic       mode,
    output logic [7:0] value
);

    localparam logic MODE_XOR = 1'(CHK_XOR);

    // Seeding with the byte equals clearing to zero and then accumulating it.
    always_ff @(posedge clk) begin
        if (rst)
            value <= '0;
        else if (seed)
            value <= din;
        else if (acc)
            value <= (mode == MODE_XOR) ? (value ^ din) : (value + din);
    end

endmodule

// File: rtl/proto_frame_rx.sv
// Byte-stream frame parser [SOF][TYPE][LEN][PAYLOAD][CHK] with a held valid/ack output slot.
// Define PROTO_RX_TIMEOUT_EN to enable the inter-byte timeout (TIMEOUT_CYC cycles).
module proto_frame_rx
    import proto_pkg::*;
#(
    parameter int         MAX_LEN        = 32,
    parameter logic [7:0] SOF            = SOF_DEFAULT,
    parameter int         CHK_MODE       = CHK_SUM,
    parameter int         ALLOW_ZERO_LEN = 0,
    parameter int         TIMEOUT_CYC    = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           pkt_type,
    output logic [7:0]           pkt_len,
    output logic [8*MAX_LEN-1:0] payload_bus,
    output logic                 pkt_valid,
    input  logic                 pkt_ack,
    output logic                 err_valid,
    output logic [2:0]           err_code,
    output logic [15:0]          frames_ok,
    output logic [15:0]          frames_bad
);

    if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
        $error("proto_frame_rx: MAX_LEN must be 1..255");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("proto_frame_rx: TIMEOUT_CYC must be >= 2");
    end

    state_t               state, state_nx;
    logic [7:0]           stg_type, stg_len, idx;
    logic [8*MAX_LEN-1:0] stg_pay;
    logic [7:0]           chk_val;
    logic                 timeout;
    logic                 chk_seed, chk_acc, pay_clear, pay_wr, commit, err_req;
    err_t                 err_nx;
    logic                 slot_free, len_big;

    assign slot_free = !pkt_valid || pkt_ack;
    assign len_big   = {24'd0, rx_data} > 32'(MAX_LEN);

    proto_chk_acc u_chk (
        .clk   (clk),
        .rst   (rst),
        .seed  (chk_seed),
        .acc   (chk_acc),
        .din   (rx_data),
        .mode  (CHK_MODE == CHK_XOR),
        .value (chk_val)
    );

`ifdef PROTO_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;

    // A byte landing on the expiry cycle wins over the timeout.
    assign timeout = (state != ST_IDLE) && !rx_valid && (to_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || state == ST_IDLE || rx_valid)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TW'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        chk_seed  = 1'b0;
        chk_acc   = 1'b0;
        pay_clear = 1'b0;
        pay_wr    = 1'b0;
        commit    = 1'b0;
        err_req   = 1'b0;
        err_nx    = ERR_NONE;
        if (timeout) begin
            state_nx = ST_IDLE;
            err_req  = 1'b1;
            err_nx   = ERR_TIMEOUT;
        end else if (rx_valid) begin
            unique case (state)
                ST_IDLE: if (rx_data == SOF) state_nx = ST_TYPE;
                ST_TYPE: begin
                    chk_seed = 1'b1;
                    state_nx = ST_LEN;
                end
                ST_LEN: begin
                    chk_acc = 1'b1;
                    if (len_big || (rx_data == 8'd0 && ALLOW_ZERO_LEN == 0)) begin
                        err_req  = 1'b1;
                        err_nx   = ERR_BAD_LEN;
                        state_nx = ST_IDLE;
                    end else begin
                        pay_clear = 1'b1;
                        state_nx  = (rx_data == 8'd0) ? ST_CHK : ST_PAY;
                    end
                end
                ST_PAY: begin
                    chk_acc = 1'b1;
                    pay_wr  = 1'b1;
                    if (idx + 8'd1 == stg_len) state_nx = ST_CHK;
                end
                ST_CHK: begin
                    state_nx = ST_IDLE;
                    if (rx_data != chk_val) begin
                        err_req = 1'b1;
                        err_nx  = ERR_BAD_CHK;
                    end else if (slot_free) begin
                        commit = 1'b1;
                    end else begin
                        err_req = 1'b1;
                        err_nx  = ERR_OVERRUN;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Staging: cleared on every accepted LEN so zero-length frames commit an all-zero payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_type <= '0;
            stg_len  <= '0;
            idx      <= '0;
            stg_pay  <= '0;
        end else begin
            if (chk_seed) stg_type <= rx_data;
            if (pay_clear) begin
                stg_len <= rx_data;
                idx     <= '0;
                stg_pay <= '0;
            end else if (pay_wr) begin
                idx <= idx + 8'd1;
                for (int k = 0; k < MAX_LEN; k++)
                    if (idx == 8'(k)) stg_pay[8*(MAX_LEN-1-k) +: 8] <= rx_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_type    <= '0;
            pkt_len     <= '0;
            payload_bus <= '0;
            pkt_valid   <= 1'b0;
            err_valid   <= 1'b0;
            err_code    <= '0;
            frames_ok   <= '0;
            frames_bad  <= '0;
        end else begin
            err_valid <= err_req;
            if (err_req) begin
                err_code <= err_nx;
                if (frames_bad != 16'hFFFF) frames_bad <= frames_bad + 16'd1;
            end
            if (commit) begin
                pkt_type    <= stg_type;
                pkt_len     <= stg_len;
                payload_bus <= stg_pay;
                pkt_valid   <= 1'b1;
                if (frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
            end else if (pkt_ack) begin
                pkt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_proto_frame_rx.sv
// Scoreboard bench: two parser instances (sum/no-zero-len and xor/zero-len) on one byte stream.
`timescale 1ns/1ps
module tb_proto_frame_rx;

    localparam int         MAXL     = 8;
    localparam int         TCYC     = 16;
    localparam logic [7:0] SOFB     = 8'hAA;
    localparam int         KIND_PKT = 0;
    localparam int         KIND_ERR = 1;

    typedef struct {
        int              d;
        int              kind;
        logic [2:0]      code;
        logic [7:0]      typ;
        logic [7:0]      len;
        logic [8*MAXL-1:0] pay;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic rx_valid = 1'b0;
    logic pkt_ack = 1'b0;

    logic [1:0][7:0]        ptype, plen;
    logic [1:0][8*MAXL-1:0] pbus;
    logic [1:0]             pvalid, evalid;
    logic [1:0][2:0]        ecode;
    logic [1:0][15:0]       fok, fbad;

    always #5 clk = ~clk;

    proto_frame_rx #(.MAX_LEN(MAXL), .SOF(SOFB), .CHK_MODE(0), .ALLOW_ZERO_LEN(0), .TIMEOUT_CYC(TCYC)) dut0 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .pkt_type(ptype[0]), .pkt_len(plen[0]), .payload_bus(pbus[0]), .pkt_valid(pvalid[0]),
        .pkt_ack(pkt_ack), .err_valid(evalid[0]), .err_code(ecode[0]),
        .frames_ok(fok[0]), .frames_bad(fbad[0]));

    proto_frame_rx #(.MAX_LEN(MAXL), .SOF(SOFB), .CHK_MODE(1), .ALLOW_ZERO_LEN(1), .TIMEOUT_CYC(TCYC)) dut1 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .pkt_type(ptype[1]), .pkt_len(plen[1]), .payload_bus(pbus[1]), .pkt_valid(pvalid[1]),
        .pkt_ack(pkt_ack), .err_valid(evalid[1]), .err_code(ecode[1]),
        .frames_ok(fok[1]), .frames_bad(fbad[1]));

    int checks = 0;
    int errors = 0;

    exp_t expq[$];
    int   full[2];
    int   okc[2];
    int   badc[2];
    logic [7:0] fpay[MAXL];
    bit   rand_gaps = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    task automatic take(input int d, output exp_t e, output bit found);
        e = '{default: 0};
        found = 1'b0;
        for (int i = 0; i < expq.size(); i++) begin
            if (expq[i].d == d) begin
                e = expq[i];
                expq.delete(i);
                found = 1'b1;
                break;
            end
        end
    endtask

    // Monitor: error pulses and frames_ok steps are the DUT's output events.
    exp_t       held[2];
    logic [15:0] last_ok[2];
    logic [2:0]  last_code[2];
    always @(negedge clk) begin
        exp_t e;
        bit   found;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                held[d]      = '{default: 0};
                last_ok[d]   = 16'd0;
                last_code[d] = 3'd0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (evalid[d]) begin
                    take(d, e, found);
                    if (!found) begin
                        checks++; errors++;
                        $display("FAIL unexpected_err dut%0d actual=%0d required=none @%0t", d, ecode[d], $time);
                    end else begin
                        chk($sformatf("err_kind dut%0d", d), 64'(KIND_ERR), 64'(e.kind));
                        chk($sformatf("err_code dut%0d", d), 64'(ecode[d]), 64'(e.code));
                        last_code[d] = e.code;
                    end
                end else begin
                    chk($sformatf("err_code_hold dut%0d", d), 64'(ecode[d]), 64'(last_code[d]));
                end
                if (fok[d] != last_ok[d]) begin
                    take(d, e, found);
                    if (!found) begin
                        checks++; errors++;
                        $display("FAIL unexpected_pkt dut%0d actual=%0h required=none @%0t", d, ptype[d], $time);
                    end else begin
                        chk($sformatf("pkt_kind dut%0d", d), 64'(e.kind), 64'(KIND_PKT));
                        chk($sformatf("pkt_type dut%0d", d), 64'(ptype[d]), 64'(e.typ));
                        chk($sformatf("pkt_len dut%0d", d), 64'(plen[d]), 64'(e.len));
                        chk($sformatf("payload dut%0d", d), 64'(pbus[d]), 64'(e.pay));
                        chk($sformatf("pkt_valid_on_commit dut%0d", d), 64'(pvalid[d]), 64'd1);
                        chk($sformatf("frames_ok_step dut%0d", d), 64'(fok[d]), 64'(last_ok[d]) + 64'd1);
                        if (e.kind == KIND_PKT) held[d] = e;
                    end
                    last_ok[d] = fok[d];
                end else begin
                    chk($sformatf("hold_type dut%0d", d), 64'(ptype[d]), 64'(held[d].typ));
                    chk($sformatf("hold_len dut%0d", d), 64'(plen[d]), 64'(held[d].len));
                    chk($sformatf("hold_payload dut%0d", d), 64'(pbus[d]), 64'(held[d].pay));
                end
            end
        end
    end

    task automatic push_err(input int d, input logic [2:0] c);
        exp_t e;
        e = '{default: 0};
        e.d = d; e.kind = KIND_ERR; e.code = c;
        expq.push_back(e);
        badc[d]++;
    endtask

    task automatic push_pkt(input int d, input logic [7:0] t, input logic [7:0] l, input logic [8*MAXL-1:0] p);
        exp_t e;
        e = '{default: 0};
        e.d = d; e.kind = KIND_PKT; e.typ = t; e.len = l; e.pay = p;
        expq.push_back(e);
        okc[d]++;
        full[d] = 1;
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic ack);
        rx_data = b; rx_valid = 1'b1; pkt_ack = ack;
        @(posedge clk); #1;
        rx_valid = 1'b0; pkt_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic gap();
        if (rand_gaps) idle(int'($urandom_range(0, 2)));
    endtask

    task automatic check_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s pkt_valid dut%0d", tag, d), 64'(pvalid[d]), 64'(full[d]));
            chk($sformatf("%s frames_ok dut%0d", tag, d), 64'(fok[d]), 64'(okc[d]));
            chk($sformatf("%s frames_bad dut%0d", tag, d), 64'(fbad[d]), 64'(badc[d]));
        end
    endtask

    task automatic ack_cycle();
        pkt_ack = 1'b1;
        @(posedge clk); #1;
        pkt_ack = 1'b0;
        full[0] = 0; full[1] = 0;
        check_state("ack");
    endtask

    // chk_sel: 0 sum, 1 xor, 2 random, 3 sum+1. gap_type >= 0 forces the TYPE->LEN gap.
    task automatic send_frame(input logic [7:0] typ, input logic [7:0] len, input int chk_sel,
                              input bit ack_chk, input int gap_type);
        logic [7:0] sum, xr, cb;
        logic [8*MAXL-1:0] pay;
        bit bl[2];
        bit good;
        sum = 8'(typ + len);
        xr  = typ ^ len;
        pay = '0;
        if (int'(len) <= MAXL)
            for (int k = 0; k < int'(len); k++) begin
                sum = 8'(sum + fpay[k]);
                xr  = xr ^ fpay[k];
                pay[8*(MAXL-1-k) +: 8] = fpay[k];
            end
        case (chk_sel)
            0: cb = sum;
            1: cb = xr;
            3: cb = 8'(sum + 8'd1);
            default: cb = 8'($urandom);
        endcase
        // dut0 is idle while the zero-length CHK byte passes; keep it from looking like SOF.
        if (len == 8'd0 && cb == SOFB) cb = cb ^ 8'h01;
        bl[0] = (int'(len) > MAXL) || (len == 8'd0);
        bl[1] = (int'(len) > MAXL);
        for (int d = 0; d < 2; d++) begin
            if (bl[d]) begin
                push_err(d, 3'd1);
                if (ack_chk && !bl[1-d]) full[d] = 0;
            end else begin
                good = (cb == ((d == 1) ? xr : sum));
                if (!good) begin
                    push_err(d, 3'd2);
                    if (ack_chk) full[d] = 0;
                end else if (full[d] == 0 || ack_chk) begin
                    push_pkt(d, typ, len, pay);
                end else begin
                    push_err(d, 3'd3);
                end
            end
        end
        drive_byte(SOFB, 1'b0); gap();
        drive_byte(typ, 1'b0);
        if (gap_type >= 0) idle(gap_type); else gap();
        drive_byte(len, 1'b0);
        if (!(bl[0] && bl[1])) begin
            for (int k = 0; k < int'(len); k++) begin
                gap();
                drive_byte(fpay[k], 1'b0);
            end
            gap();
            drive_byte(cb, ack_chk);
        end
        check_state("frame");
    endtask

    task automatic set_pay2(input logic [7:0] a, input logic [7:0] b);
        for (int k = 0; k < MAXL; k++) fpay[k] = 8'd0;
        fpay[0] = a; fpay[1] = b;
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s pkt_valid dut%0d", tag, d), 64'(pvalid[d]), 64'd0);
            chk($sformatf("%s err_valid dut%0d", tag, d), 64'(evalid[d]), 64'd0);
            chk($sformatf("%s err_code dut%0d", tag, d), 64'(ecode[d]), 64'd0);
            chk($sformatf("%s frames_ok dut%0d", tag, d), 64'(fok[d]), 64'd0);
            chk($sformatf("%s frames_bad dut%0d", tag, d), 64'(fbad[d]), 64'd0);
            chk($sformatf("%s pkt_type dut%0d", tag, d), 64'(ptype[d]), 64'd0);
            chk($sformatf("%s pkt_len dut%0d", tag, d), 64'(plen[d]), 64'd0);
            chk($sformatf("%s payload dut%0d", tag, d), 64'(pbus[d]), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] noise;
        for (int d = 0; d < 2; d++) begin full[d] = 0; okc[d] = 0; badc[d] = 0; end
        rst = 1'b1;
        idle(2);
        check_zero("reset");
        rst = 1'b0;
        idle(1);

        // Spec example frame: sum and xor are both 0x33.
        set_pay2(8'h10, 8'h20);
        send_frame(8'h01, 8'h02, 0, 1'b0, -1);
        ack_cycle();
        // Bad checksum, then an immediate good frame.
        send_frame(8'h01, 8'h02, 3, 1'b0, -1);
        send_frame(8'h01, 8'h02, 0, 1'b0, -1);
        ack_cycle();
        // Length boundaries.
        send_frame(8'h05, 8'(MAXL + 1), 0, 1'b0, -1);
        send_frame(8'h05, 8'hFF, 0, 1'b0, -1);
        for (int k = 0; k < MAXL; k++) fpay[k] = 8'($urandom);
        send_frame(8'h06, 8'(MAXL), 1, 1'b0, -1);
        ack_cycle();
        send_frame(8'h05, 8'h00, 0, 1'b0, -1);
        ack_cycle();
        // Overrun, then ack on the same edge as a commit.
        set_pay2(8'h10, 8'h20);
        send_frame(8'h01, 8'h02, 0, 1'b0, -1);
        set_pay2(8'h04, 8'h08);
        send_frame(8'h01, 8'h02, 0, 1'b0, -1);
        send_frame(8'h01, 8'h02, 0, 1'b1, -1);
        ack_cycle();
        ack_cycle();

`ifdef PROTO_RX_TIMEOUT_EN
        drive_byte(SOFB, 1'b0);
        drive_byte(8'h01, 1'b0);
        push_err(0, 3'd4);
        push_err(1, 3'd4);
        idle(TCYC);
        idle(1);
        check_state("timeout");
        set_pay2(8'h10, 8'h20);
        send_frame(8'h01, 8'h02, 0, 1'b0, TCYC - 1);
        ack_cycle();
`endif

        // Reset mid-payload discards the partial frame silently.
        idle(2);
        drive_byte(SOFB, 1'b0);
        drive_byte(8'h01, 1'b0);
        drive_byte(8'h04, 1'b0);
        drive_byte(8'h11, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("midreset");
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin full[d] = 0; okc[d] = 0; badc[d] = 0; end
        set_pay2(8'h10, 8'h20);
        send_frame(8'h01, 8'h02, 0, 1'b0, -1);

        for (int n = 0; n < 300; n++) begin
            int r;
            if ($urandom_range(0, 1) == 1) ack_cycle();
            if ($urandom_range(0, 5) == 0) begin
                noise = 8'($urandom);
                if (noise == SOFB) noise = 8'h00;
                drive_byte(noise, 1'b0);
            end
            for (int k = 0; k < MAXL; k++) fpay[k] = 8'($urandom);
            r = int'($urandom_range(0, 9));
            send_frame(8'($urandom),
                       (r < 8) ? 8'(r + 1) : (r == 8) ? 8'h00 : (($urandom_range(0, 1) == 1) ? 8'hFF : 8'(MAXL + 1)),
                       int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), -1);
        end

        idle(4);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0 pending", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/proto_frame_rx.md
# proto_frame_rx

Second-generation byte-stream frame parser for the RFID link: accepts framed packets `[SOF][TYPE][LEN][PAYLOAD×LEN][CHK]` from the UART byte interface. It buffers the payload and presents complete packets on a held valid/ack output slot. Adds selectable checksum mode, configurable SOF, optional zero-length frames, overrun detection, coded errors, saturating statistics and a compile-time inter-byte timeout. Sits between the UART receiver and the command decoder.

## Interface
- `MAX_LEN`, 32: maximum payload bytes, range 1–255.
- `SOF`, 8'hAA: start-of-frame byte.
- `CHK_MODE`, 0: 0 = 8-bit sum mod 256, 1 = XOR; covers TYPE, LEN and all payload bytes.
- `ALLOW_ZERO_LEN`, 0: 1 accepts LEN=0, so CHK directly follows LEN.
- `TIMEOUT_CYC`, 1000: inter-byte timeout in clock cycles, ≥2; only used with the macro.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid when high.
- `pkt_type`  out  8  type of the held packet.
- `pkt_len`  out  8  length of the held packet.
- `payload_bus`  out  8*MAX_LEN  payload, MSB-first: byte k at `[8*(MAX_LEN-1-k) +: 8]`; unused bytes are 0.
- `pkt_valid`  out  1  output slot holds a good packet.
- `pkt_ack`  in  1  consumer accepts the packet.
- `err_valid`  out  1  one-cycle error pulse.
- `err_code`  out  3  1 BAD_LEN, 2 BAD_CHK, 3 OVERRUN, 4 TIMEOUT; holds its last value between pulses.
- `frames_ok`  out  16  count of good frames delivered; saturates at 16'hFFFF.
- `frames_bad`  out  16  count of err_valid pulses; saturates at 16'hFFFF.

## Operation
- States are IDLE, TYPE, LEN, PAY and CHK. Only edges with `rx_valid`=1 advance the state, except on timeout.
- IDLE: `rx_data`==SOF → TYPE; any other byte is discarded.
- TYPE: store the type in staging, seed the checksum with the byte → LEN. A byte equal to SOF outside IDLE is treated as data; there is no resync.
- LEN: a length >MAX_LEN, or 0 with ALLOW_ZERO_LEN=0, raises BAD_LEN → IDLE. A length of 0 that is allowed → CHK. Otherwise clear the staging payload, set idx=0 → PAY.
- PAY: write the byte to staging at idx, accumulate it, increment idx. When idx+1==LEN → CHK.
- CHK: on mismatch raise BAD_CHK → IDLE. On match:
  - Commit staging to the output registers if the slot is free (`pkt_valid`=0, or `pkt_ack`=1 on the same edge), set `pkt_valid`, increment `frames_ok`.
  - Otherwise drop the frame and raise OVERRUN; the held packet is untouched.
  - → IDLE.
- The output registers change only on commit. They stay stable while `pkt_valid`=1.
- Every error pulse increments `frames_bad`.

## Timing
- Reset clears state to IDLE. All outputs, staging, idx, the checksum and both counters reset to 0.
- Reset mid-frame discards the partial frame with no error. Reset takes priority over every other event.
- `pkt_valid` rises on the clock after the edge that samples the CHK byte. `err_valid` pulses on the clock after the offending byte.
- Handshake: `pkt_valid`=1 and `pkt_ack`=1 on an edge consumes the packet, and `pkt_valid` falls next cycle. If a commit happens on that same edge, `pkt_valid` stays 1 and the new data appears.
- `pkt_ack` while `pkt_valid`=0 is ignored.
- Back-to-back frames with no idle cycles are supported. The SOF of the next frame may arrive on the cycle directly after CHK.
- The checksum is 8-bit and wraps.

## Configuration
- `PROTO_RX_TIMEOUT_EN` defined:
  - A counter clears on every `rx_valid` and while in IDLE, and increments otherwise.
  - Outside IDLE, reaching TIMEOUT_CYC consecutive cycles without `rx_valid` forces IDLE and raises TIMEOUT.
  - A byte arriving on the expiry cycle is processed normally, with no timeout.
- Not defined: no counter exists, the parser waits indefinitely, and code 4 is never produced.

## Structure
- Package `proto_pkg`: default SOF constant, state enum, `err_code` enum, CHK_MODE constants (CHK_SUM, CHK_XOR).
- One sub-module, `proto_chk_acc`:
  - holds the running checksum;
  - ports: clear/seed, accumulate enable, byte in, mode, current value.
- The FSM, staging buffer, output slot and counters live in `proto_frame_rx`.

## Test plan
- Good frame: AA 01 02 10 20 33 (sum) → `pkt_valid`=1, type 01, len 02, top bytes 10 20 and rest 0, `frames_ok`=1. The same bytes with CHK_MODE=1 also pass, since the XOR is also 33.
- Bad checksum: AA 01 02 10 20 34 → err_valid pulse with code 2, no pkt_valid, `frames_bad`=1. An immediate good frame afterward is accepted.
- Bad length with MAX_LEN=32: AA 05 21 → code 1, back to IDLE. AA 05 00 with ALLOW_ZERO_LEN=0 → code 1. With ALLOW_ZERO_LEN=1, AA 05 00 05 → pkt_valid, len 0.
- Overrun: two good frames, `pkt_ack` held 0 → the first packet is retained, code 3 after the second CHK. Assert `pkt_ack` on the same edge as the second commit → the second packet replaces the first and `pkt_valid` stays high.
- Timeout with the macro and TIMEOUT_CYC=16: AA 01, then a 16-cycle gap → code 4, IDLE. A gap of 15 followed by a byte → no error.
- Reset mid-payload after AA 01 04 11 → all outputs 0, no error. A following good frame parses correctly.
